// File: rtl/spike_time_decoder.sv
// Race-logic spike-time decoder: stamps the first rising edge of each gamma cycle and queues one result word per close.
// Build option: SPIKE_DECODER_NOSPIKE_REPORT_EN also queues {G-1, nospike} for gammas that saw no spike.
module spike_time_decoder #(
   parameter int  GAMMA_CYCLE_WIDTH = 16,
   parameter int  FIFO_DEPTH        = 4,
   localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH),
   localparam int AW                = $clog2(FIFO_DEPTH)
) (
   input  logic          aclk,
   input  logic          rst,
   input  logic          grst,
   input  logic          in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [TW-1:0] out_time,
   output logic          out_nospike,
   output logic          out_trunc,
   output logic          overflow
);

   typedef struct packed {
      logic [TW-1:0] tstamp;
`ifdef SPIKE_DECODER_NOSPIKE_REPORT_EN
      logic          nospike;
`endif
      logic          trunc;
   } word_t;

   logic [TW-1:0] p_reg, p_cur, cap_time;
   logic          in_q, cap_valid, armed;
   logic          spike_edge, cap_en, close_norm, close_trunc, has_cap;
   logic          push, pop, full, accept;
   word_t         push_word, head;
   word_t         mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;

   always_comb begin
      p_cur       = grst ? '0 : p_reg;
      spike_edge  = in & ~in_q;
      cap_en      = armed | grst;
      close_trunc = armed & grst & (p_reg != '0);
      close_norm  = armed & (p_cur == TW'(GAMMA_CYCLE_WIDTH - 1));
      // A grst-cycle edge belongs to the new gamma, so only a normal close may count it.
      has_cap     = close_trunc ? cap_valid : (cap_valid | spike_edge);
      push_word        = '0;
      push_word.tstamp = !has_cap  ? TW'(GAMMA_CYCLE_WIDTH - 1) :
                         cap_valid ? cap_time : p_cur;
      push_word.trunc  = close_trunc;
`ifdef SPIKE_DECODER_NOSPIKE_REPORT_EN
      push_word.nospike = ~has_cap;
      push              = close_trunc | close_norm;
`else
      push              = (close_trunc | close_norm) & has_cap;
`endif
   end

   assign full      = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
   assign out_valid = (wr_ptr != rd_ptr);
   assign pop       = out_valid & out_ready;
   assign accept    = push & (~full | pop);

   always_ff @(posedge aclk) begin
      if (rst) begin
         p_reg     <= '0;
         in_q      <= 1'b0;
         cap_valid <= 1'b0;
         cap_time  <= '0;
         armed     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         p_reg <= p_cur + TW'(1);
         in_q  <= in;
         if (grst) armed <= 1'b1;
         if (close_trunc) begin
            cap_valid <= spike_edge;
            cap_time  <= '0;
         end else if (close_norm) begin
            cap_valid <= 1'b0;
         end else if (cap_en & spike_edge & ~cap_valid) begin
            cap_valid <= 1'b1;
            cap_time  <= p_cur;
         end
         if (accept) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push & ~accept) overflow <= 1'b1;
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_time  = head.tstamp;
   assign out_trunc = head.trunc;
`ifdef SPIKE_DECODER_NOSPIKE_REPORT_EN
   assign out_nospike = head.nospike;
`else
   assign out_nospike = 1'b0;
`endif

endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed bench for spike_time_decoder (G=16, depth 4): stimulus queues expected words, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_spike_time_decoder;
   localparam int G  = 16;
   localparam int TW = 4;
`ifdef SPIKE_DECODER_NOSPIKE_REPORT_EN
   localparam int NS_EN = 1;
`else
   localparam int NS_EN = 0;
`endif

   logic          aclk = 1'b0;
   logic          rst = 1'b1, grst = 1'b0, in = 1'b0, out_ready = 1'b1;
   logic          out_valid, out_nospike, out_trunc, overflow;
   logic [TW-1:0] out_time;
   int            nvec = 0, nfail = 0;
   logic [TW+1:0] exp_q [$];

   always #5 aclk = ~aclk;

   spike_time_decoder #(.GAMMA_CYCLE_WIDTH(G), .FIFO_DEPTH(4)) dut (
      .aclk(aclk), .rst(rst), .grst(grst), .in(in),
      .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
      .out_nospike(out_nospike), .out_trunc(out_trunc), .overflow(overflow)
   );

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic expect_word(input int t, input bit ns, input bit tr);
      logic [TW-1:0] tv;
      tv = t[TW-1:0];
      exp_q.push_back({tv, ns, tr});
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // One gamma: grst on phase 0, pulses at e1/e2 (or held high from e1); optional out_valid check around the close.
   task automatic run_gamma(input int len, input int e1, input int e2, input bit hold, input int vexp);
      for (int ph = 0; ph < len; ph++) begin
         if (ph == len - 1 && vexp >= 0) chk("valid_before_close", int'(out_valid), 0);
         grst = (ph == 0);
         in   = hold ? (e1 >= 0 && ph >= e1) : (ph == e1 || ph == e2);
         tick();
      end
      if (vexp >= 0) chk("valid_after_close", int'(out_valid), vexp);
   endtask

   // Monitor: each accepted head word must match the oldest expectation.
   always @(negedge aclk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_word: got t=%0d ns=%0d tr=%0d, expected no word",
                     out_time, out_nospike, out_trunc);
         end else begin
            logic [TW+1:0] w;
            w = exp_q.pop_front();
            chk("word{t,ns,tr}", int'({out_time, out_nospike, out_trunc}), int'(w));
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_time", int'(out_time), 0);
      chk("rst_nospike", int'(out_nospike), 0);
      chk("rst_trunc", int'(out_trunc), 0);
      chk("rst_overflow", int'(overflow), 0);
      rst = 1'b0;

      // Edge before any grst must be ignored.
      tick();
      in = 1'b1; tick();
      in = 1'b0; tick(); tick(); tick();
      chk("prearm_valid", int'(out_valid), 0);

      expect_word(5, 0, 0);
      run_gamma(16, 5, -1, 1'b1, 1);
      expect_word(3, 0, 0);
      run_gamma(16, 3, 9, 1'b0, 1);
      if (NS_EN != 0) expect_word(15, 1, 0);
      run_gamma(16, -1, -1, 1'b0, NS_EN);

      expect_word(7, 0, 1);
      expect_word(0, 0, 0);
      run_gamma(10, 7, -1, 1'b0, -1);
      run_gamma(16, 0, -1, 1'b0, 1);

      // grst held 3 cycles: two 1-cycle truncated gammas, then a full gamma with an edge at phase 5.
      if (NS_EN != 0) begin
         expect_word(15, 1, 1);
         expect_word(15, 1, 1);
      end
      expect_word(5, 0, 0);
      for (int c = 0; c < 18; c++) begin
         if (c == 17) chk("held_valid_before_close", int'(out_valid), 0);
         grst = (c < 3);
         in   = (c == 7);
         tick();
      end
      chk("held_valid_after_close", int'(out_valid), 1);

      // Stall: the word from the previous gamma plus the next three fill the FIFO.
      out_ready = 1'b0;
      expect_word(1, 0, 0);
      expect_word(2, 0, 0);
      expect_word(3, 0, 0);
      for (int g = 1; g <= 6; g++) begin
         run_gamma(16, g, -1, 1'b0, -1);
         if (g == 3) chk("full_no_overflow", int'(overflow), 0);
      end
      chk("overflow_set", int'(overflow), 1);
      chk("stall_head_time", int'(out_time), 5);
      out_ready = 1'b1;
      expect_word(8, 0, 0);
      run_gamma(16, 8, -1, 1'b0, 1);
      chk("overflow_sticky", int'(overflow), 1);

      // Word for this gamma is discarded by rst.
      run_gamma(16, 4, -1, 1'b0, 1);
      rst = 1'b1; grst = 1'b0; in = 1'b0;
      tick();
      chk("rst2_overflow", int'(overflow), 0);
      chk("rst2_valid", int'(out_valid), 0);
      chk("rst2_time", int'(out_time), 0);
      chk("rst2_trunc", int'(out_trunc), 0);
      rst = 1'b0;
      in = 1'b1; tick();
      in = 1'b0; tick(); tick();
      chk("rst2_prearm_valid", int'(out_valid), 0);

      expect_word(10, 0, 0);
      run_gamma(16, 10, -1, 1'b0, 1);
      grst = 1'b0; in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("scoreboard_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
